vga_scan: RTL and testbench

VGA_SCAN -- requirements
Module: vga_scan

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_scan_if.sv | 28 ++
 rtl/vga_tick_gen.sv | 49 ++++
 rtl/vga_scan.sv | 116 +++++++++++
 tb/tb_vga_scan.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 scan timing for the scanner, sprite and collision blocks.
package vga_pkg;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int POS_W  = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    function automatic logic in_span(input logic [POS_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_if.sv
// Pixel-side bundle between the scan generator and the sprite/colour logic.
interface vga_scan_if;

    logic [11:0] pix_rgb;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        video_on;
    logic        update_tick;
    logic        toggle_tick;
    logic        hs;
    logic        vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    modport master (
        input  pix_rgb,
        output col, row, video_on, update_tick, toggle_tick,
        output hs, vs, vga_r, vga_g, vga_b
    );

    modport slave (
        output pix_rgb,
        input  col, row, video_on, update_tick, toggle_tick,
        input  hs, vs, vga_r, vga_g, vga_b
    );

endinterface

// File: rtl/vga_tick_gen.sv
// Per-frame game update strobe and every-N-frames animation toggle strobe.
module vga_tick_gen #(
    parameter int TOGGLE_FRAMES = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_pre,
    output logic update_tick,
    output logic toggle_tick
);

    localparam int FC_W = (TOGGLE_FRAMES > 1) ? $clog2(TOGGLE_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(TOGGLE_FRAMES - 1);

    logic [FC_W-1:0] fc_q, fc_d;
    logic            upd_q, upd_d;
    logic            tog_q, tog_d;

    // frame_pre arrives one clk early so both strobes come out of flops
    always_comb begin
        fc_d  = fc_q;
        upd_d = frame_pre;
        tog_d = 1'b0;
        if (frame_pre) begin
            if (fc_q == FC_LAST) begin
                fc_d  = '0;
                tog_d = 1'b1;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q  <= '0;
            upd_q <= 1'b0;
            tog_q <= 1'b0;
        end else begin
            fc_q  <= fc_d;
            upd_q <= upd_d;
            tog_q <= tog_d;
        end
    end

    assign update_tick = upd_q;
    assign toggle_tick = tog_q;

endmodule

// File: rtl/vga_scan.sv
// VGA raster scanner: pixel divider, col/row counters, registered sync/colour stage.
module vga_scan
    import vga_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int TOGGLE_FRAMES = 6,
    parameter int P_H_VIS       = H_VIS,
    parameter int P_H_FP        = H_FP,
    parameter int P_H_SYNC      = H_SYNC,
    parameter int P_H_BP        = H_BP,
    parameter int P_V_VIS       = V_VIS,
    parameter int P_V_FP        = V_FP,
    parameter int P_V_SYNC      = V_SYNC,
    parameter int P_V_BP        = V_BP
) (
    input logic        clk,
    input logic        rst,
    vga_scan_if.master bus
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int H_TOT_N = P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int V_TOT_N = P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP;
    localparam int HS_LO   = P_H_VIS + P_H_FP;
    localparam int HS_HI   = HS_LO + P_H_SYNC - 1;
    localparam int VS_LO   = P_V_VIS + P_V_FP;
    localparam int VS_HI   = VS_LO + P_V_SYNC - 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [POS_W-1:0] col_q, col_d;
    logic [POS_W-1:0] row_q, row_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    rgb_t             rgb_q, rgb_d;

    logic pix_en;
    logic video_on;
    logic hs_raw;
    logic vs_raw;
    logic frame_pre;

    always_comb begin
        pix_en = (div_q == DIV_LAST);
        div_d  = pix_en ? '0 : div_q + DIV_W'(1);
        col_d  = col_q;
        row_d  = row_q;
        if (pix_en) begin
            if (int'(col_q) == H_TOT_N - 1) begin
                col_d = '0;
                row_d = (int'(row_q) == V_TOT_N - 1) ? '0 : row_q + POS_W'(1);
            end else begin
                col_d = col_q + POS_W'(1);
            end
        end
    end

    always_comb begin
        video_on = (int'(col_q) < P_H_VIS) && (int'(row_q) < P_V_VIS);
        hs_raw   = !in_span(col_q, HS_LO, HS_HI);
        vs_raw   = !in_span(row_q, VS_LO, VS_HI);
        hs_d     = hs_q;
        vs_d     = vs_q;
        rgb_d    = rgb_q;
        if (pix_en) begin
            hs_d  = hs_raw;
            vs_d  = vs_raw;
            rgb_d = video_on ? rgb_t'(bus.pix_rgb) : '0;
        end
    end

    // True when the coming cycle is the pix_en that steps into the first blanking line
    always_comb begin
        frame_pre = (div_d == DIV_LAST)
                 && (int'(col_d) == H_TOT_N - 1)
                 && (int'(row_d) == P_V_VIS - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            col_q <= '0;
            row_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
        end else begin
            div_q <= div_d;
            col_q <= col_d;
            row_q <= row_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
        end
    end

    vga_tick_gen #(
        .TOGGLE_FRAMES(TOGGLE_FRAMES)
    ) u_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .frame_pre  (frame_pre),
        .update_tick(bus.update_tick),
        .toggle_tick(bus.toggle_tick)
    );

    assign bus.col      = col_q;
    assign bus.row      = row_q;
    assign bus.video_on = video_on;
    assign bus.hs       = hs_q;
    assign bus.vs       = vs_q;
    assign bus.vga_r    = rgb_q.r;
    assign bus.vga_g    = rgb_q.g;
    assign bus.vga_b    = rgb_q.b;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan on a shrunken raster, checked every clk against an arithmetic scan model.
module tb_vga_scan;

    localparam int D  = 3;
    localparam int TF = 3;
    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_scan_if bus();
    vga_scan_if bus1();

    vga_scan #(
        .CLK_DIV(D), .TOGGLE_FRAMES(TF),
        .P_H_VIS(HV), .P_H_FP(HF), .P_H_SYNC(HS), .P_H_BP(HB),
        .P_V_VIS(VV), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vga_scan #(
        .CLK_DIV(D), .TOGGLE_FRAMES(1),
        .P_H_VIS(HV), .P_H_FP(HF), .P_H_SYNC(HS), .P_H_BP(HB),
        .P_V_VIS(VV), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB)
    ) dut_tf1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    // k counts clk edges since the last edge that sampled rst high
    int k;
    int tick_n;
    int checks;
    int errors;
    int seen_upd;
    int seen_tog;
    bit const_mode;
    logic [11:0] cur_rgb;
    logic exp_hs, exp_vs;
    logic [11:0] exp_rgb;
    logic pend, pend_hs, pend_vs;
    logic [11:0] pend_rgb;

    function automatic int col_of(input int kk);
        return (kk / D) % HT;
    endfunction

    function automatic int row_of(input int kk);
        return ((kk / D) / HT) % VT;
    endfunction

    function automatic bit tick_at(input int kk);
        return (kk % D == D - 1) && (col_of(kk) == HT - 1) && (row_of(kk) == VV - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int c, r;
        logic ven, upd, tog;
        c   = col_of(k);
        r   = row_of(k);
        ven = (c < HV) && (r < VV);
        upd = tick_at(k);
        if (upd) tick_n++;
        tog = upd && (tick_n % TF == 0);
        chk("col", 32'(bus.col), c);
        chk("row", 32'(bus.row), r);
        chk("video_on", 32'(bus.video_on), 32'(ven));
        chk("hs", 32'(bus.hs), 32'(exp_hs));
        chk("vs", 32'(bus.vs), 32'(exp_vs));
        chk("vga_r", 32'(bus.vga_r), 32'(exp_rgb[11:8]));
        chk("vga_g", 32'(bus.vga_g), 32'(exp_rgb[7:4]));
        chk("vga_b", 32'(bus.vga_b), 32'(exp_rgb[3:0]));
        chk("update_tick", 32'(bus.update_tick), 32'(upd));
        chk("toggle_tick", 32'(bus.toggle_tick), 32'(tog));
        chk("tf1_update", 32'(bus1.update_tick), 32'(upd));
        chk("tf1_toggle", 32'(bus1.toggle_tick), 32'(upd));
        if (bus.update_tick === 1'b1) seen_upd++;
        if (bus.toggle_tick === 1'b1) seen_tog++;
    endtask

    task automatic drive_pix();
        cur_rgb      = const_mode ? 12'hABC : 12'($urandom);
        bus.pix_rgb  = cur_rgb;
        bus1.pix_rgb = cur_rgb;
    endtask

    task automatic step(input logic rst_v);
        int c, r;
        rst = rst_v;
        @(posedge clk);
        if (rst_v) begin
            k        = 0;
            tick_n   = 0;
            seen_upd = 0;
            seen_tog = 0;
            exp_hs   = 1'b1;
            exp_vs   = 1'b1;
            exp_rgb  = '0;
        end else begin
            k++;
            if (pend) begin
                exp_hs  = pend_hs;
                exp_vs  = pend_vs;
                exp_rgb = pend_rgb;
            end
        end
        pend = 1'b0;
        @(negedge clk);
        check_cycle();
        if (k % D == 0) drive_pix();
        if (k % D == D - 1) begin
            c        = col_of(k);
            r        = row_of(k);
            pend     = 1'b1;
            pend_hs  = !((c >= HV + HF) && (c < HV + HF + HS));
            pend_vs  = !((r >= VV + VF) && (r < VV + VF + VS));
            pend_rgb = ((c < HV) && (r < VV)) ? cur_rgb : 12'h000;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        k          = 0;
        tick_n     = 0;
        seen_upd   = 0;
        seen_tog   = 0;
        pend       = 1'b0;
        const_mode = 1'b0;
        exp_hs     = 1'b1;
        exp_vs     = 1'b1;
        exp_rgb    = '0;
        drive_pix();

        repeat (3) step(1'b1);

        // 13 frames of random colour: 13 updates, toggles on the 3rd/6th/9th/12th
        repeat (13 * FRAME) step(1'b0);
        chk("frames13_updates", 32'(seen_upd), 13);
        chk("frames13_toggles", 32'(seen_tog), 13 / TF);

        const_mode = 1'b1;
        repeat (2 * FRAME) step(1'b0);
        const_mode = 1'b0;

        // one-clk reset in the middle of the visible area
        for (int i = 0; i < FRAME && !(col_of(k) == 10 && row_of(k) == 7); i++) step(1'b0);
        step(1'b1);
        repeat (FRAME + 50) step(1'b0);
        chk("restart_updates", 32'(seen_upd), 1);

        // reset landing on the clk just before an update strobe must swallow it
        for (int i = 0; i < FRAME && !tick_at(k + 1); i++) step(1'b0);
        step(1'b1);
        chk("abort_updates", 32'(seen_upd), 0);
        repeat (FRAME) step(1'b0);
        chk("after_abort_updates", 32'(seen_upd), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
